// File: rtl/seq_det_pkg.sv
// Shared definitions for the parameterised serial sequence detector.
// Holds the FSM state encoding, which is also driven onto the 'state' port.
package seq_det_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,  // unconfigured, input ignored
    ST_FILL  = 2'b01,  // configured, history not yet len bits deep
    ST_ARMED = 2'b10,  // history full, no hit on the last bit
    ST_HIT   = 2'b11   // a match was flagged this cycle
  } state_e;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter used for the detection count.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   inc        : count up by one (holds at all-ones)
//   clr        : clear to zero; wins over inc
//   cnt        : registered count value
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Clear beats increment; increment stops at the all-ones value.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with overlap control and a
// saturating hit counter.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   cfg_load            : latch cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern         : pattern, bit cfg_len-1 received first, bit 0 last
//   cfg_len             : active pattern length (2..PAT_MAX accepted)
//   cfg_overlap         : 1 = overlapping detection, 0 = non-overlapping
//   in_valid, data_in   : serial input, sampled only while in_valid is high
//   cnt_clr             : clear match_count
//   match               : one-cycle registered pulse per detection
//   match_count         : saturating detection count
//   state               : FSM state (IDLE/FILL/ARMED/HIT)
//   cfg_err             : sticky, last load was rejected
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter  int unsigned PAT_MAX = 8,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               data_in,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic [1:0]         state,
  output logic               cfg_err
);

  state_e             r_state, w_state_nxt;
  logic [PAT_MAX-2:0] r_hist,  w_hist_nxt;   // top history bit is never compared
  logic [LEN_W-1:0]   r_fill,  w_fill_nxt;
  logic [PAT_MAX-1:0] r_pat,   w_pat_nxt;
  logic [LEN_W-1:0]   r_len,   w_len_nxt;
  logic               r_ovl,   w_ovl_nxt;
  logic               r_err,   w_err_nxt;
  logic               r_match, w_match_nxt;

  logic               w_hit;
  logic               w_len_ok;
  logic [PAT_MAX-1:0] w_shift;
  logic [PAT_MAX-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_inc;

  assign w_len_ok   = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(PAT_MAX));
  assign w_shift    = {r_hist, data_in};
  assign w_fill_inc = (r_fill < r_len) ? (r_fill + LEN_W'(1)) : r_fill;

  // Only the low len bits of history and pattern take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(PAT_MAX); i++) begin
      w_mask[i] = (32'(i) < 32'(r_len));
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= '0;
      r_len   <= '0;
      r_ovl   <= 1'b0;
      r_err   <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_pat   <= w_pat_nxt;
      r_len   <= w_len_nxt;
      r_ovl   <= w_ovl_nxt;
      r_err   <= w_err_nxt;
      r_match <= w_match_nxt;
    end
  end

  // Next-state: a load beats data; IDLE ignores data until a good load.
  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_pat_nxt   = r_pat;
    w_len_nxt   = r_len;
    w_ovl_nxt   = r_ovl;
    w_err_nxt   = r_err;
    w_match_nxt = 1'b0;
    w_hit       = 1'b0;

    if (cfg_load) begin
      w_hist_nxt = '0;
      w_fill_nxt = '0;
      if (w_len_ok) begin
        w_pat_nxt   = cfg_pattern;
        w_len_nxt   = cfg_len;
        w_ovl_nxt   = cfg_overlap;
        w_err_nxt   = 1'b0;
        w_state_nxt = ST_FILL;
      end else begin
        w_pat_nxt   = '0;
        w_len_nxt   = '0;
        w_ovl_nxt   = 1'b0;
        w_err_nxt   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    end else if (r_state != ST_IDLE) begin
      if (in_valid) begin
        w_hist_nxt = w_shift[PAT_MAX-2:0];
        if ((w_fill_inc == r_len) && (((w_shift ^ r_pat) & w_mask) == '0)) begin
          w_hit       = 1'b1;
          w_match_nxt = 1'b1;
          w_state_nxt = ST_HIT;
          // Non-overlapping mode restarts the fill so matched bits are not reused.
          w_fill_nxt  = r_ovl ? w_fill_inc : '0;
        end else begin
          w_fill_nxt  = w_fill_inc;
          w_state_nxt = (w_fill_inc == r_len) ? ST_ARMED : ST_FILL;
        end
      end else if (r_state == ST_HIT) begin
        w_state_nxt = (r_fill == r_len) ? ST_ARMED : ST_FILL;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_hit),
    .clr   (cnt_clr),
    .cnt   (match_count)
  );

  assign match   = r_match;
  assign state   = r_state;
  assign cfg_err = r_err;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: one default instance (CNT_W=8) and
// one narrow-counter instance (CNT_W=2) driven by the same stimulus.
module tb_seq_detector_param;
  import seq_det_pkg::*;

  logic       clk = 1'b0;
  logic       reset, cfg_load, cfg_overlap, in_valid, data_in, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;

  logic       match_a, match_b, err_a, err_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b, state_a, state_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_MAX(8), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .data_in(data_in), .cnt_clr(cnt_clr), .match(match_a),
    .match_count(cnt_a), .state(state_a), .cfg_err(err_a)
  );

  seq_detector_param #(.PAT_MAX(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .data_in(data_in), .cnt_clr(cnt_clr), .match(match_b),
    .match_count(cnt_b), .state(state_b), .cfg_err(err_b)
  );

  // Stream 1,0,1,1,0,1,1 (first bit at index 6) and expectations for 1011/len4.
  bit [6:0] stream  = 7'b1011011;
  bit [6:0] m_ovl   = 7'b0001001;
  bit [6:0] m_novl  = 7'b0001000;
  state_e   st_ovl  [7] = '{ST_FILL, ST_FILL, ST_FILL, ST_HIT, ST_ARMED, ST_ARMED, ST_HIT};
  state_e   st_novl [7] = '{ST_FILL, ST_FILL, ST_FILL, ST_HIT, ST_FILL, ST_FILL, ST_FILL};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1;
    data_in  = b;
    step();
    in_valid = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic clear_count();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_overlap = 1'b0; in_valid = 1'b0;
    data_in = 1'b0; cnt_clr = 1'b0; cfg_pattern = '0; cfg_len = '0;
    step();
    step();
    reset = 1'b0;

    check("rst state", 32'(state_a), 32'(ST_IDLE));
    check("rst match", 32'(match_a), 32'd0);
    check("rst count", 32'(cnt_a), 32'd0);
    check("rst err",   32'(err_a), 32'd0);

    // Overlapping 1011; upper pattern bits set to prove they are masked.
    load(8'hFB, 4'd4, 1'b1);
    check("s1 load state", 32'(state_a), 32'(ST_FILL));
    for (int i = 0; i < 7; i++) begin
      send(stream[6-i]);
      check($sformatf("s1 match b%0d", i+1), 32'(match_a), 32'(m_ovl[6-i]));
      check($sformatf("s1 state b%0d", i+1), 32'(state_a), 32'(st_ovl[i]));
    end
    check("s1 count", 32'(cnt_a), 32'd2);
    step();
    check("s1 idle match", 32'(match_a), 32'd0);
    check("s1 idle state", 32'(state_a), 32'(ST_ARMED));

    // Non-overlapping; load must not touch the count.
    load(8'h0B, 4'd4, 1'b0);
    check("s2 load keeps count", 32'(cnt_a), 32'd2);
    clear_count();
    check("s2 cleared", 32'(cnt_a), 32'd0);
    for (int i = 0; i < 7; i++) begin
      send(stream[6-i]);
      check($sformatf("s2 match b%0d", i+1), 32'(match_a), 32'(m_novl[6-i]));
      check($sformatf("s2 state b%0d", i+1), 32'(state_a), 32'(st_novl[i]));
    end
    check("s2 count", 32'(cnt_a), 32'd1);

    // Gapped overlapping stream; the load cycle carries a bit that must be dropped.
    in_valid = 1'b1;
    data_in  = 1'b1;
    load(8'h0B, 4'd4, 1'b1);
    in_valid = 1'b0;
    clear_count();
    for (int i = 0; i < 7; i++) begin
      send(stream[6-i]);
      check($sformatf("s3 match b%0d", i+1), 32'(match_a), 32'(m_ovl[6-i]));
      check($sformatf("s3 state b%0d", i+1), 32'(state_a), 32'(st_ovl[i]));
      for (int g = 0; g <= (i % 3); g++) begin
        data_in = 1'($urandom_range(0, 1));
        step();
        check($sformatf("s3 gap match b%0d", i+1), 32'(match_a), 32'd0);
        check($sformatf("s3 gap state b%0d", i+1), 32'(state_a),
              32'((st_ovl[i] == ST_HIT) ? ST_ARMED : st_ovl[i]));
      end
    end
    check("s3 count", 32'(cnt_a), 32'd2);

    // Illegal lengths are rejected and leave the block deaf to data.
    load(8'h03, 4'd1, 1'b1);
    check("s4 len1 err",   32'(err_a),   32'd1);
    check("s4 len1 state", 32'(state_a), 32'(ST_IDLE));
    for (int i = 0; i < 20; i++) begin
      send(1'($urandom_range(0, 1)));
      check($sformatf("s4 idle match %0d", i), 32'(match_a), 32'd0);
      check($sformatf("s4 idle state %0d", i), 32'(state_a), 32'(ST_IDLE));
    end
    check("s4 count held", 32'(cnt_a), 32'd2);
    load(8'hFF, 4'd9, 1'b1);
    check("s4 len9 err", 32'(err_a), 32'd1);
    load(8'h0B, 4'd4, 1'b1);
    check("s4 good err",   32'(err_a),   32'd0);
    check("s4 good state", 32'(state_a), 32'(ST_FILL));

    // Full-width pattern 1100_1010.
    load(8'hCA, 4'd8, 1'b0);
    for (int i = 7; i >= 1; i--) begin
      cfg_pattern = 8'hCA;
      send(cfg_pattern[i]);
    end
    check("s5 len8 b7 match", 32'(match_a), 32'd0);
    check("s5 len8 b7 state", 32'(state_a), 32'(ST_FILL));
    send(1'b0);
    check("s5 len8 b8 match", 32'(match_a), 32'd1);
    check("s5 len8 b8 state", 32'(state_a), 32'(ST_HIT));

    // Pattern 11 overlapping: six ones give five back-to-back hits.
    load(8'h03, 4'd2, 1'b1);
    clear_count();
    send(1'b1);
    check("s6 first match", 32'(match_a), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      send(1'b1);
      check($sformatf("s6 match a h%0d", i), 32'(match_a), 32'd1);
      check($sformatf("s6 match b h%0d", i), 32'(match_b), 32'd1);
      check($sformatf("s6 cnt8 h%0d", i), 32'(cnt_a), 32'(i));
      check($sformatf("s6 cnt2 h%0d", i), 32'(cnt_b), 32'((i > 3) ? 3 : i));
    end
    cnt_clr = 1'b1;
    send(1'b1);
    cnt_clr = 1'b0;
    check("s6 clr+hit match", 32'(match_b), 32'd1);
    check("s6 clr+hit cnt2",  32'(cnt_b),   32'd0);
    check("s6 clr+hit cnt8",  32'(cnt_a),   32'd0);

    // Reset mid-pattern, with load and data asserted alongside it.
    load(8'h0B, 4'd4, 1'b1);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    reset = 1'b1; cfg_load = 1'b1; in_valid = 1'b1; data_in = 1'b1; cnt_clr = 1'b0;
    step();
    reset = 1'b0; cfg_load = 1'b0; in_valid = 1'b0; data_in = 1'b0;
    check("s7 rst state", 32'(state_a), 32'(ST_IDLE));
    check("s7 rst err",   32'(err_b),   32'd0);
    check("s7 rst state b", 32'(state_b), 32'(ST_IDLE));
    send(1'b1);
    check("s7 match", 32'(match_a), 32'd0);
    check("s7 state", 32'(state_a), 32'(ST_IDLE));
    check("s7 count", 32'(cnt_a),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_MAX, default 8, maximum pattern length in bits; legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8, match counter width; legal range 2..32.
REQ-003 SHALL derive localparam LEN_W = $clog2(PAT_MAX+1).
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high; clock clk.
REQ-006 SHALL have port cfg_load  in  1  latch cfg_pattern/cfg_len/cfg_overlap this cycle.
REQ-007 SHALL have port cfg_pattern  in  PAT_MAX  pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
REQ-008 SHALL have port cfg_len  in  LEN_W  active pattern length.
REQ-009 SHALL have port cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 SHALL have port in_valid  in  1  data_in is sampled only when high.
REQ-011 SHALL have port data_in  in  1  serial input bit.
REQ-012 SHALL have port cnt_clr  in  1  clear match_count.
REQ-013 SHALL have port match  out  1  registered one-cycle pulse per detection.
REQ-014 SHALL have port match_count  out  CNT_W  saturating detection count.
REQ-015 SHALL have port state  out  2  FSM state: IDLE=00, FILL=01, ARMED=10, HIT=11.
REQ-016 SHALL have port cfg_err  out  1  sticky flag: last load was rejected.

Function
REQ-017 SHALL accept a load only when 2 <= cfg_len <= PAT_MAX; an accepted load stores the config, clears the history and fill count, clears cfg_err, and sets state to FILL.
REQ-018 SHALL treat a rejected load by setting cfg_err=1 and state=IDLE and marking the block unconfigured; the history is cleared.
REQ-019 SHALL ignore all data_in while in IDLE.
REQ-020 SHALL give cfg_load priority over in_valid in the same cycle; that data bit is discarded.
REQ-021 SHALL, on each accepted bit, shift it into bit 0 of the history (hist <= {hist[PAT_MAX-2:0], data_in}) and set fill = min(fill+1, len).
REQ-022 SHALL detect a hit when the post-shift fill equals len and the post-shift history's low len bits equal the pattern's low len bits; bits at len and above are masked out.
REQ-023 SHALL on a hit set match=1 and state=HIT in the next cycle, a latency of 1 clock after the accepting edge.
REQ-024 SHALL on a hit leave fill at len when overlap=1, or reset fill to 0 when overlap=0.
REQ-025 SHALL otherwise set state to ARMED if fill==len, else FILL; on cycles with in_valid=0, match=0 and HIT exits to ARMED or FILL by the same rule.
REQ-026 SHALL allow back-to-back hits in overlap mode, holding match high on consecutive cycles.
REQ-027 SHALL increment match_count on each hit and saturate it at 2^CNT_W-1.
REQ-028 SHALL give cnt_clr priority over a simultaneous hit, leaving the count at 0; match still pulses.
REQ-029 SHALL leave match_count unchanged on cfg_load.

Reset
REQ-030 SHALL on reset clear match, match_count, cfg_err, history, fill and the stored config, and enter IDLE.
REQ-031 SHALL give reset priority over cfg_load, cnt_clr and in_valid, and shall discard any partial pattern.

Structure
REQ-032 SHALL place the state encoding constants (IDLE, FILL, ARMED, HIT) in shared package seq_det_pkg.
REQ-033 SHALL implement the saturating counter as sub-module sat_counter (parameter W; inputs inc and clr, where clr wins).

Verification
REQ-034 SHALL cover this scenario: PAT_MAX=8, load 1011/len4/overlap=1, stream 1,0,1,1,0,1,1 -> match after bits 4 and 7, count=2.
REQ-035 SHALL cover this scenario: same stream, overlap=0 -> match after bit 4 only, count=1.
REQ-036 SHALL cover this scenario: same as REQ-034 with in_valid=0 gaps of 1-3 cycles between bits -> identical match bit positions, state holds during gaps.
REQ-037 SHALL cover this scenario: load len=1 -> cfg_err=1, state=IDLE, no match for 20 random bits; then a valid load -> cfg_err=0, state=FILL.
REQ-038 SHALL cover this scenario: reset after bits 1,0,1, then release and send 1 -> no match, state=IDLE, count=0.
REQ-039 SHALL cover this scenario: CNT_W=2, 5 overlap hits of pattern 11 -> count saturates at 3; cnt_clr coincident with a hit -> count=0 and match=1.
